// File: rtl/command_bus_master.sv
// command_bus_master: host-side master turning single-word requests into GPU command-port bus cycles.
module command_bus_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqRead,
  input  logic [15:0] reqCommand,
  input  logic [15:0] reqData,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        busy,
  output logic        chipSelect,
  output logic        outputEnable,
  output logic        commandClk,
  output logic [15:0] command,
  inout  wire  [15:0] dataInOut
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, RISE, FALL, TA_RISE, TA_FALL} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_q, rd_d;
  logic [15:0] cmd_q, cmd_d, wdata_q, wdata_d;
  logic ready_q, rsp_valid_q, busy_q, cs_q, oe_q, cclk_q, drive_q;
  logic [15:0] rsp_data_q, command_q, dout_q;
  logic last, accept, on_bus, capture;
  always_comb begin
    last = cnt_q == LAST;
    accept = state_q == IDLE && reqValid && ready_q;
    capture = state_q == FALL && last && rd_q;
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    cmd_d = cmd_q;
    wdata_d = wdata_q;
    if (accept) begin
      state_d = SETUP;
      cnt_d = '0;
      rd_d = reqRead;
      cmd_d = reqCommand;
      wdata_d = reqData;
    end else if (state_q != IDLE) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        case (state_q)
          SETUP:   state_d = RISE;
          RISE:    state_d = FALL;
          FALL:    state_d = rd_q ? TA_RISE : IDLE;
          TA_RISE: state_d = TA_FALL;
          default: state_d = IDLE;
        endcase
      end
    end
    on_bus = state_d == SETUP || state_d == RISE || state_d == FALL;
  end
  // Bus outputs are registered from the next state so pins line up with the state they belong to.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= 1'b0;
      cmd_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      busy_q <= 1'b0;
      cs_q <= 1'b0;
      oe_q <= 1'b0;
      cclk_q <= 1'b0;
      drive_q <= 1'b0;
      command_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      cmd_q <= cmd_d;
      wdata_q <= wdata_d;
      ready_q <= state_d == IDLE;
      busy_q <= state_d != IDLE;
      cs_q <= on_bus;
      oe_q <= on_bus && rd_d;
      cclk_q <= state_d == RISE || state_d == TA_RISE;
      drive_q <= on_bus && !rd_d;
      command_q <= on_bus ? cmd_d : '0;
      dout_q <= on_bus && !rd_d ? wdata_d : '0;
      rsp_valid_q <= capture;
      if (capture) rsp_data_q <= dataInOut;
    end
  end
  assign reqReady = ready_q;
  assign rspValid = rsp_valid_q;
  assign rspData = rsp_data_q;
  assign busy = busy_q;
  assign chipSelect = cs_q;
  assign outputEnable = oe_q;
  assign commandClk = cclk_q;
  assign command = command_q;
  assign dataInOut = drive_q ? dout_q : 16'hzzzz;
endmodule
